// File: rtl/lms_pkg.sv
// Shared definitions for the block-LMS datapath controllers: state codes,
// stage indices and default geometry.
package lms_pkg;

    localparam int LMS_N   = 32;
    localparam int LMS_AW  = 6;
    localparam int LMS_TMO = 1023;
    localparam int LMS_CW  = 16;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_BLK = 3'd1;
    localparam logic [2:0] ST_FFT1     = 3'd2;
    localparam logic [2:0] ST_FILT     = 3'd3;
    localparam logic [2:0] ST_ERR      = 3'd4;
    localparam logic [2:0] ST_FFT3     = 3'd5;
    localparam logic [2:0] ST_UPD      = 3'd6;
    localparam logic [2:0] ST_SWAP     = 3'd7;

    typedef enum logic [2:0] {
        STG_FFT1 = 3'd0,
        STG_FILT = 3'd1,
        STG_ERR  = 3'd2,
        STG_FFT3 = 3'd3,
        STG_UPD  = 3'd4
    } lms_stage_e;

    // Stage states are laid out contiguously starting at ST_FFT1.
    function automatic logic [2:0] stage_state(lms_stage_e stg);
        logic [2:0] idx;
        idx = stg;
        return ST_FFT1 + idx;
    endfunction

endpackage

// File: rtl/lms_block_sequencer_if.sv
// Start/done handshake between the block sequencer and the processing engines.
interface lms_block_sequencer_if;
    logic fft1_start;
    logic fft1_done;
    logic filt_start;
    logic filt_done;
    logic err_start;
    logic err_done;
    logic fft3_start;
    logic fft3_done;
    logic upd_start;
    logic upd_done;

    modport master (
        output fft1_start, filt_start, err_start, fft3_start, upd_start,
        input  fft1_done, filt_done, err_done, fft3_done, upd_done
    );

    modport slave (
        input  fft1_start, filt_start, err_start, fft3_start, upd_start,
        output fft1_done, filt_done, err_done, fft3_done, upd_done
    );
endinterface

// File: rtl/lms_blk_counter.sv
// Overlap-save write pointer and block detector. Runs regardless of the
// sequencer state so samples are never stalled; one completed block can be
// held pending, a further one while pending is dropped and flagged.
module lms_blk_counter #(
    parameter int N  = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic          pend_clr,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] cand_base,
    output logic          pend,
    output logic          overrun
);
    localparam int SW = AW - 1;

    logic [SW-1:0] samp_cnt;
    logic [AW-1:0] wr_addr_nx;
    logic          blk_ready;

    // The post-increment address is the next write slot, i.e. the oldest
    // sample of the 2N window that has just been completed.
    assign wr_addr_nx = wr_addr + 1'b1;
    assign blk_ready  = wr && (samp_cnt == SW'(N - 1));

    // Write address and sample counter, both wrapping naturally (N is a power of 2).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_addr  <= '0;
            samp_cnt <= '0;
        end else if (wr) begin
            wr_addr  <= wr_addr_nx;
            samp_cnt <= samp_cnt + 1'b1;
        end
    end

    // Pending block slot; a block arriving on the same edge the slot is freed is kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend      <= 1'b0;
            cand_base <= '0;
            overrun   <= 1'b0;
        end else if (blk_ready && pend && !pend_clr) begin
            overrun <= 1'b1;
        end else if (blk_ready) begin
            pend      <= 1'b1;
            cand_base <= wr_addr_nx;
        end else if (pend_clr) begin
            pend <= 1'b0;
        end
    end
endmodule

// File: rtl/lms_block_sequencer.sv
// Frame-level sequencer for the FFT block-LMS datapath.
//
//   state    | meaning
//   IDLE     | stopped, waits for enable
//   WAIT_BLK | waits for a pending block, falls back to IDLE without enable
//   FFT1     | forward FFT of the input window
//   FILT     | coefficient multiply and IFFT
//   ERR      | error save/subtract and zero insert
//   FFT3     | error FFT
//   UPD      | gradient constraint and coefficient update
//   SWAP     | flip coefficient bank, count the frame
module lms_block_sequencer
    import lms_pkg::*;
#(
    parameter int N   = LMS_N,
    parameter int AW  = LMS_AW,
    parameter int TMO = LMS_TMO,
    parameter int CW  = LMS_CW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic [AW-1:0]         buf_wr_addr,
    output logic                  buf_wr_en,
    output logic [AW-1:0]         blk_base,
    lms_block_sequencer_if.master eng,
    output logic                  coef_rd_bank,
    output logic                  busy,
    output logic [2:0]            state_o,
    output logic [CW-1:0]         frame_cnt,
    output logic                  overrun,
    output logic                  timeout
);
    localparam int TW = $clog2(TMO + 1);

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic          first;
    logic [TW-1:0] tmr;
    logic          take;
    logic          tmo_hit;
    logic          pend;
    logic [AW-1:0] cand_base;

    assign buf_wr_en = in_valid && (enable || (state != ST_IDLE));
    assign busy      = (state != ST_IDLE) && (state != ST_WAIT_BLK);
    assign state_o   = state;

    assign eng.fft1_start = first && (state == stage_state(STG_FFT1));
    assign eng.filt_start = first && (state == stage_state(STG_FILT));
    assign eng.err_start  = first && (state == stage_state(STG_ERR));
    assign eng.fft3_start = first && (state == stage_state(STG_FFT3));
    assign eng.upd_start  = first && (state == stage_state(STG_UPD));

    lms_blk_counter #(
        .N  (N),
        .AW (AW)
    ) u_blk_counter (
        .clk       (clk),
        .reset     (reset),
        .wr        (buf_wr_en),
        .pend_clr  (take || tmo_hit),
        .wr_addr   (buf_wr_addr),
        .cand_base (cand_base),
        .pend      (pend),
        .overrun   (overrun)
    );

    // Next state; a done is honoured even on the last timer cycle.
    always_comb begin
        state_nx = state;
        take     = 1'b0;
        tmo_hit  = 1'b0;
        case (state)
            ST_IDLE: if (enable) state_nx = ST_WAIT_BLK;
            ST_WAIT_BLK: begin
                if (pend) begin
                    take     = 1'b1;
                    state_nx = ST_FFT1;
                end else if (!enable) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_FFT1: if (eng.fft1_done) state_nx = ST_FILT; else if (tmr == '0) tmo_hit = 1'b1;
            ST_FILT: if (eng.filt_done) state_nx = ST_ERR;  else if (tmr == '0) tmo_hit = 1'b1;
            ST_ERR:  if (eng.err_done)  state_nx = ST_FFT3; else if (tmr == '0) tmo_hit = 1'b1;
            ST_FFT3: if (eng.fft3_done) state_nx = ST_UPD;  else if (tmr == '0) tmo_hit = 1'b1;
            ST_UPD:  if (eng.upd_done)  state_nx = ST_SWAP; else if (tmr == '0) tmo_hit = 1'b1;
            ST_SWAP: state_nx = ST_WAIT_BLK;
            default: state_nx = ST_IDLE;
        endcase
        if (tmo_hit) state_nx = ST_IDLE;
    end

    // State register, entry marker for the start strobes, and the per-state
    // down-counter (reloaded on every entry so a stage gets TMO cycles).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            first <= 1'b0;
            tmr   <= '0;
        end else begin
            state <= state_nx;
            first <= (state_nx != state);
            if (state_nx != state) begin
                tmr <= TW'(TMO - 1);
            end else if (tmr != '0) begin
                tmr <= tmr - 1'b1;
            end
        end
    end

    // Iteration bookkeeping: window base, bank select, frame count, timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_base     <= '0;
            coef_rd_bank <= 1'b0;
            frame_cnt    <= '0;
            timeout      <= 1'b0;
        end else begin
            if (take) blk_base <= cand_base;
            if (state == ST_SWAP) begin
                coef_rd_bank <= ~coef_rd_bank;
                frame_cnt    <= frame_cnt + 1'b1;
            end
            if (tmo_hit) timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lms_block_sequencer.sv
// Directed bench for lms_block_sequencer with N=8 (16-entry window) and TMO=15.
module tb_lms_block_sequencer;
    import lms_pkg::*;

    localparam int N   = 8;
    localparam int AW  = 4;
    localparam int TMO = 15;
    localparam int CW  = 16;
    localparam int OW  = 2 * AW + CW + 13;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          enable   = 1'b0;
    logic          in_valid = 1'b0;
    logic [AW-1:0] buf_wr_addr;
    logic          buf_wr_en;
    logic [AW-1:0] blk_base;
    logic          coef_rd_bank;
    logic          busy;
    logic [2:0]    state_o;
    logic [CW-1:0] frame_cnt;
    logic          overrun;
    logic          timeout;

    lms_block_sequencer_if eng ();

    // bit order: 0 FFT1, 1 FILT, 2 ERR, 3 FFT3, 4 UPD
    logic [4:0] st_vec;
    logic [4:0] prev_start = '0;
    logic [4:0] auto_done  = '0;
    logic [4:0] auto_mask  = 5'b11111;
    logic [4:0] man_done   = '0;
    int         seq_log[$];
    int         start_cnt  = 0;
    int         overlap    = 0;
    int         n_cmp      = 0;
    int         n_err      = 0;

    wire [OW-1:0] all_out = {buf_wr_addr, buf_wr_en, blk_base, st_vec, coef_rd_bank,
                             busy, state_o, frame_cnt, overrun, timeout};

    assign st_vec = {eng.upd_start, eng.fft3_start, eng.err_start, eng.filt_start, eng.fft1_start};
    assign eng.fft1_done = auto_done[0] | man_done[0];
    assign eng.filt_done = auto_done[1] | man_done[1];
    assign eng.err_done  = auto_done[2] | man_done[2];
    assign eng.fft3_done = auto_done[3] | man_done[3];
    assign eng.upd_done  = auto_done[4] | man_done[4];

    lms_block_sequencer #(.N(N), .AW(AW), .TMO(TMO), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .in_valid     (in_valid),
        .buf_wr_addr  (buf_wr_addr),
        .buf_wr_en    (buf_wr_en),
        .blk_base     (blk_base),
        .eng          (eng),
        .coef_rd_bank (coef_rd_bank),
        .busy         (busy),
        .state_o      (state_o),
        .frame_cnt    (frame_cnt),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Engine model: answers each start with a done in the following cycle
    // (per-stage mask), and logs every start pulse in order.
    always @(negedge clk) begin
        auto_done  = auto_mask & prev_start;
        prev_start = st_vec;
        if ($countones(st_vec) > 1) overlap++;
        for (int i = 0; i < 5; i++) begin
            if (st_vec[i]) begin
                seq_log.push_back(i);
                start_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic feed_block();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_frame(input int target);
        bit ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (frame_cnt == CW'(target)) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL wait_frame: frame_cnt=%0d never reached %0d", frame_cnt, target);
        end
    endtask

    task automatic wait_start(input int idx);
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (st_vec[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL wait_start: stage %0d start never seen, got none want pulse", idx);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (all_out !== '0) begin
            n_err++;
            $display("FAIL rst_outputs: got %h want 0", all_out);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (state_o !== ST_IDLE) begin
            n_err++;
            $display("FAIL rst_idle_state: got %0d want %0d", state_o, ST_IDLE);
        end
        n_cmp++;
        if (all_out !== '0) begin
            n_err++;
            $display("FAIL rst_release_outputs: got %h want 0", all_out);
        end
    endtask

    task automatic test_startup();
        enable = 1'b1;
        feed_block();
        n_cmp++;
        if (state_o !== ST_WAIT_BLK || st_vec !== 5'b0) begin
            n_err++;
            $display("FAIL start_k1: state=%0d starts=%b want state=1 starts=0", state_o, st_vec);
        end
        n_cmp++;
        if (buf_wr_addr !== 4'd8) begin
            n_err++;
            $display("FAIL start_wr_addr: got %0d want 8", buf_wr_addr);
        end
        @(negedge clk);
        n_cmp++;
        if (st_vec !== 5'b00001) begin
            n_err++;
            $display("FAIL start_fft1: starts=%b want 00001", st_vec);
        end
        n_cmp++;
        if (blk_base !== 4'd8) begin
            n_err++;
            $display("FAIL start_blk_base: got %0d want 8", blk_base);
        end
        n_cmp++;
        if (state_o !== ST_FFT1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_state: state=%0d busy=%b want 2/1", state_o, busy);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        wait_frame(1);
        feed_block();
        wait_frame(2);
        n_cmp++;
        if (blk_base !== 4'd0) begin
            n_err++;
            $display("FAIL b2b_base2: got %0d want 0", blk_base);
        end
        feed_block();
        wait_frame(3);
        n_cmp++;
        if (blk_base !== 4'd8) begin
            n_err++;
            $display("FAIL b2b_base3: got %0d want 8", blk_base);
        end
        n_cmp++;
        if (frame_cnt !== 16'd3 || coef_rd_bank !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_frame_bank: frame=%0d bank=%b want 3/1", frame_cnt, coef_rd_bank);
        end
        if (seq_log.size() != 15) bad = 1;
        else for (int i = 0; i < 15; i++) if (seq_log[i] != i % 5) bad++;
        n_cmp++;
        if (bad != 0 || start_cnt != 15) begin
            n_err++;
            $display("FAIL b2b_order: starts=%0d bad=%0d want 15/0", start_cnt, bad);
        end
        n_cmp++;
        if (overlap != 0) begin
            n_err++;
            $display("FAIL b2b_overlap: got %0d want 0", overlap);
        end
    endtask

    task automatic test_overrun();
        int e_cyc = -1;
        auto_mask[2] = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            in_valid = (c < 24);
            if (eng.err_start && e_cyc < 0) e_cyc = c;
            man_done[2] = (e_cyc >= 0) && (c == e_cyc + 12);
            if (e_cyc >= 0 && c == e_cyc + 13) auto_mask[2] = 1'b1;
            if (c == 23) begin
                n_cmp++;
                if (overrun !== 1'b0) begin
                    n_err++;
                    $display("FAIL ovr_before: got %b want 0", overrun);
                end
            end
            if (c == 24) begin
                n_cmp++;
                if (overrun !== 1'b1) begin
                    n_err++;
                    $display("FAIL ovr_set: got %b want 1", overrun);
                end
            end
            if (c == 32) begin
                n_cmp++;
                if (st_vec !== 5'b00001 || blk_base !== 4'd8) begin
                    n_err++;
                    $display("FAIL ovr_next_base: starts=%b base=%0d want 00001/8", st_vec, blk_base);
                end
            end
        end
        n_cmp++;
        if (e_cyc != 13) begin
            n_err++;
            $display("FAIL ovr_err_start: cycle %0d want 13", e_cyc);
        end
        n_cmp++;
        if (frame_cnt !== 16'd5 || state_o !== ST_WAIT_BLK || overrun !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_end: frame=%0d state=%0d ovr=%b want 5/1/1", frame_cnt, state_o, overrun);
        end
    endtask

    task automatic test_timeout();
        int snap;
        auto_mask = 5'b10111;
        feed_block();
        wait_start(3);
        enable = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 14) begin
                n_cmp++;
                if (timeout !== 1'b0) begin
                    n_err++;
                    $display("FAIL tmo_early: got %b want 0 at cycle 14", timeout);
                end
            end
        end
        n_cmp++;
        if (timeout !== 1'b1 || state_o !== ST_IDLE) begin
            n_err++;
            $display("FAIL tmo_set: timeout=%b state=%0d want 1/0", timeout, state_o);
        end
        snap = start_cnt;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (start_cnt != snap || state_o !== ST_IDLE || busy !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_quiet: starts=%0d state=%0d busy=%b want %0d/0/0", start_cnt, state_o, busy, snap);
        end
        in_valid = 1'b1;
        #1;
        n_cmp++;
        if (buf_wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_wr_en: got %b want 0", buf_wr_en);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (buf_wr_addr !== 4'd8) begin
            n_err++;
            $display("FAIL tmo_wr_addr: got %0d want 8", buf_wr_addr);
        end
        auto_mask = 5'b11111;
    endtask

    task automatic test_reset_mid_upd();
        enable    = 1'b1;
        auto_mask = 5'b01111;
        feed_block();
        wait_start(4);
        @(negedge clk);
        n_cmp++;
        if (state_o !== ST_UPD || frame_cnt !== 16'd5 || timeout !== 1'b1) begin
            n_err++;
            $display("FAIL mid_upd_pre: state=%0d frame=%0d tmo=%b want 6/5/1", state_o, frame_cnt, timeout);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (all_out !== '0) begin
            n_err++;
            $display("FAIL mid_upd_async: got %h want 0", all_out);
        end
        @(negedge clk);
        reset     = 1'b1;
        auto_mask = 5'b11111;
        feed_block();
        wait_start(0);
        n_cmp++;
        if (blk_base !== 4'd8 || frame_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL mid_upd_restart: base=%0d frame=%0d want 8/0", blk_base, frame_cnt);
        end
        wait_frame(1);
        n_cmp++;
        if (coef_rd_bank !== 1'b1 || overrun !== 1'b0 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL mid_upd_frame1: bank=%b ovr=%b tmo=%b want 1/0/0", coef_rd_bank, overrun, timeout);
        end
    endtask

    task automatic test_enable_drop();
        feed_block();
        wait_start(1);
        enable = 1'b0;
        wait_frame(2);
        n_cmp++;
        if (state_o !== ST_WAIT_BLK || coef_rd_bank !== 1'b0) begin
            n_err++;
            $display("FAIL endrop_wait: state=%0d bank=%b want 1/0", state_o, coef_rd_bank);
        end
        in_valid = 1'b1;
        #1;
        n_cmp++;
        if (buf_wr_en !== 1'b1) begin
            n_err++;
            $display("FAIL endrop_wr_en_wait: got %b want 1", buf_wr_en);
        end
        @(negedge clk);
        n_cmp++;
        if (state_o !== ST_IDLE) begin
            n_err++;
            $display("FAIL endrop_idle: state=%0d want 0", state_o);
        end
        #1;
        n_cmp++;
        if (buf_wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL endrop_wr_en_idle: got %b want 0", buf_wr_en);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_back_to_back();
        test_overrun();
        test_timeout();
        test_reset_mid_upd();
        test_enable_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
